// File: rtl/term_q_pkg.sv
// Shared definitions for the term scheduler and the term_quantizer integrations.
// MAG_W is tied to the quantizer's 2-bit position counter and must stay 4.
package term_q_pkg;

   localparam int MAG_W = 4;
   localparam int POS_W = 2;

   typedef enum logic [1:0] {
      FILL   = 2'd0,
      SCAN   = 2'd1,
      STREAM = 2'd2
   } sched_state_t;

   typedef struct packed {
      logic             sign;
      logic [MAG_W-1:0] mag;
   } sm_word_t;

endpackage

// File: rtl/term_plane_select.sv
// Priority keep-mask for one bit plane: the lowest-indexed set bits win
// until the remaining term budget is used up.
module term_plane_select
   import term_q_pkg::*;
#(
   parameter int GROUP    = 4,
   parameter int BUDGET_W = 5
) (
   input  logic [GROUP-1:0]    plane_i,
   input  logic [BUDGET_W-1:0] remaining_i,
   output logic [GROUP-1:0]    keep_o,
   output logic [BUDGET_W-1:0] kept_o,
   output logic [BUDGET_W-1:0] dropped_o
);

   always_comb begin
      keep_o    = '0;
      kept_o    = '0;
      dropped_o = '0;
      for (int i = 0; i < GROUP; i++) begin
         if (plane_i[i]) begin
            if (kept_o < remaining_i) begin
               keep_o[i] = 1'b1;
               kept_o    = kept_o + BUDGET_W'(1);
            end else begin
               dropped_o = dropped_o + BUDGET_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/term_stream_scheduler.sv
// Collects a group of sign-magnitude words, keeps the K most significant terms
// across the group and streams the surviving bits LSB-first into term_quantizer.
module term_stream_scheduler
   import term_q_pkg::*;
#(
   parameter int GROUP    = 4,
   parameter int BUDGET_W = 5
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [MAG_W-1:0]    in_mag,
   input  logic                in_sign,
   input  logic [BUDGET_W-1:0] cfg_budget,
   output logic                stream_bit,
   output logic                stream_sign,
   output logic                q_reset,
   output logic                busy,
   output logic                group_done,
   output logic [BUDGET_W-1:0] dropped_terms
);

   localparam int W_W   = (GROUP > 1) ? $clog2(GROUP) : 1;
   localparam int CNT_W = W_W + POS_W;
   localparam logic [W_W-1:0]   LAST_IDX = W_W'(GROUP - 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(GROUP * MAG_W - 1);

   sched_state_t        state_q;
   sm_word_t            wbuf_q [GROUP];
   logic [MAG_W-1:0]    keep_q [GROUP];
   logic [MAG_W-1:0]    keep_d [GROUP];
   logic [W_W-1:0]      idx_q;
   logic [POS_W-1:0]    plane_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [BUDGET_W-1:0] remaining_q, shadow_q, dropped_q;
   logic                stream_bit_q, stream_sign_q, q_reset_q, busy_q, group_done_q;

   logic [GROUP-1:0]    plane_bits, plane_keep;
   logic [BUDGET_W-1:0] plane_kept, plane_dropped;
   logic [CNT_W-1:0]    sel_cnt;
   logic [W_W-1:0]      sel_w;
   logic [POS_W-1:0]    sel_b;
   logic                sel_bit, sel_sign;

   term_plane_select #(.GROUP(GROUP), .BUDGET_W(BUDGET_W)) u_plane_select (
      .plane_i     (plane_bits),
      .remaining_i (remaining_q),
      .keep_o      (plane_keep),
      .kept_o      (plane_kept),
      .dropped_o   (plane_dropped)
   );

   // keep_d folds the plane being scanned into the mask so the first stream
   // bit can be registered on the same edge that finishes plane 0.
   always_comb begin
      for (int i = 0; i < GROUP; i++) begin
         plane_bits[i] = wbuf_q[i].mag[plane_q];
         keep_d[i]     = keep_q[i];
         if (state_q == SCAN) begin
            keep_d[i][plane_q] = plane_keep[i];
         end
      end
   end

   always_comb begin
      sel_cnt  = (state_q == STREAM) ? cnt_q + CNT_W'(1) : '0;
      sel_w    = sel_cnt[POS_W +: W_W];
      sel_b    = sel_cnt[POS_W-1:0];
      sel_bit  = wbuf_q[sel_w].mag[sel_b] & keep_d[sel_w][sel_b];
      sel_sign = wbuf_q[sel_w].sign & (|(wbuf_q[sel_w].mag & keep_d[sel_w]));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= FILL;
         idx_q         <= '0;
         plane_q       <= '0;
         cnt_q         <= '0;
         remaining_q   <= '0;
         shadow_q      <= '0;
         dropped_q     <= '0;
         stream_bit_q  <= 1'b0;
         stream_sign_q <= 1'b0;
         q_reset_q     <= 1'b1;
         busy_q        <= 1'b0;
         group_done_q  <= 1'b0;
         for (int i = 0; i < GROUP; i++) begin
            wbuf_q[i] <= '0;
            keep_q[i] <= '0;
         end
      end else begin
         group_done_q <= 1'b0;
         case (state_q)
            FILL: begin
               q_reset_q     <= 1'b1;
               stream_bit_q  <= 1'b0;
               stream_sign_q <= 1'b0;
               if (in_valid && in_ready) begin
                  wbuf_q[idx_q].sign <= in_sign;
                  wbuf_q[idx_q].mag  <= in_mag;
                  if (idx_q == '0) begin
                     remaining_q <= cfg_budget;
                     shadow_q    <= '0;
                  end
                  if (idx_q == LAST_IDX) begin
                     idx_q   <= '0;
                     plane_q <= POS_W'(MAG_W - 1);
                     busy_q  <= 1'b1;
                     state_q <= SCAN;
                  end else begin
                     idx_q <= idx_q + W_W'(1);
                  end
               end
            end
            SCAN: begin
               remaining_q <= remaining_q - plane_kept;
               shadow_q    <= shadow_q + plane_dropped;
               for (int i = 0; i < GROUP; i++) keep_q[i] <= keep_d[i];
               plane_q <= plane_q - POS_W'(1);
               if (plane_q == '0) begin
                  cnt_q         <= '0;
                  stream_bit_q  <= sel_bit;
                  stream_sign_q <= sel_sign;
                  q_reset_q     <= 1'b0;
                  state_q       <= STREAM;
               end
            end
            STREAM: begin
               if (cnt_q == LAST_CNT) begin
                  stream_bit_q  <= 1'b0;
                  stream_sign_q <= 1'b0;
                  q_reset_q     <= 1'b1;
                  busy_q        <= 1'b0;
                  group_done_q  <= 1'b1;
                  dropped_q     <= shadow_q;
                  state_q       <= FILL;
               end else begin
                  cnt_q         <= cnt_q + CNT_W'(1);
                  stream_bit_q  <= sel_bit;
                  stream_sign_q <= sel_sign;
               end
            end
            default: state_q <= FILL;
         endcase
      end
   end

   // The done cycle is not a fill cycle, giving the GROUP+MAG_W+GROUP*MAG_W+1 period.
   assign in_ready      = (state_q == FILL) && !group_done_q;
   assign stream_bit    = stream_bit_q;
   assign stream_sign   = stream_sign_q;
   assign q_reset       = q_reset_q;
   assign busy          = busy_q;
   assign group_done    = group_done_q;
   assign dropped_terms = dropped_q;

endmodule
